// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and helpers for the ALU arbiter.
package alu_pkg;

  localparam logic [2:0] OP_MOV = 3'b000;
  localparam logic [2:0] OP_NOT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return op != OP_ILL;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker; the last_grant register lives in the parent.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant_onehot,
  output logic       grant_id
);

  // Requester 1 wins when it is the only one asking, or when both ask and 0 was served last.
  always_comb begin
    grant_id     = valid[1] & (~valid[0] | ~last_grant);
    grant_onehot = '0;
    if (valid != 2'b00) begin
      grant_onehot = grant_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one external ALU between two valid/ready requesters, one operation in flight.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic         req1_cin,
  output logic         resp0_valid,
  input  logic         resp0_ready,
  output logic [N-1:0] resp0_data,
  output logic         resp0_cout,
  output logic         resp0_err,
  output logic         resp1_valid,
  input  logic         resp1_ready,
  output logic [N-1:0] resp1_data,
  output logic         resp1_cout,
  output logic         resp1_err,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_op,
  output logic         alu_cin,
  input  logic [N-1:0] alu_out,
  input  logic         alu_cout,
  output logic         busy
);

  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  state_t       state, state_n;
  logic         owner;
  logic         last_grant;
  logic [3:0]   cnt;
  logic [1:0]   grant_onehot;
  logic         grant_id;
  logic         accept;
  logic         owner_resp_ready;
  logic [2:0]   sel_op;
  logic [N-1:0] sel_a, sel_b;
  logic         sel_cin;

  rr_arb2 u_arb (
    .valid        ({req1_valid, req0_valid}),
    .last_grant   (last_grant),
    .grant_onehot (grant_onehot),
    .grant_id     (grant_id)
  );

  // Handshake decode and winner's request fields.
  always_comb begin
    req0_ready       = (state == ST_IDLE) & grant_onehot[0];
    req1_ready       = (state == ST_IDLE) & grant_onehot[1];
    accept           = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    sel_op           = grant_id ? req1_op  : req0_op;
    sel_a            = grant_id ? req1_a   : req0_a;
    sel_b            = grant_id ? req1_b   : req0_b;
    sel_cin          = grant_id ? req1_cin : req0_cin;
    owner_resp_ready = owner ? resp1_ready : resp0_ready;
    resp0_valid      = (state == ST_RESP) & ~owner;
    resp1_valid      = (state == ST_RESP) & owner;
    busy             = (state != ST_IDLE);
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (accept) state_n = op_legal(sel_op) ? ST_EXEC : ST_RESP;
      ST_EXEC: if (cnt == '0) state_n = ST_RESP;
      ST_RESP: if (owner_resp_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Grant bookkeeping, ALU operand registers, latency counter and per-requester results.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= OP_MOV;
      alu_cin    <= 1'b0;
      resp0_data <= '0;
      resp0_cout <= 1'b0;
      resp0_err  <= 1'b0;
      resp1_data <= '0;
      resp1_cout <= 1'b0;
      resp1_err  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            owner      <= grant_id;
            last_grant <= grant_id;
            if (op_legal(sel_op)) begin
              alu_a   <= sel_a;
              alu_b   <= sel_b;
              alu_op  <= sel_op;
              alu_cin <= sel_cin;
              cnt     <= CNT_INIT;
            end else if (grant_id) begin
              resp1_data <= '0;
              resp1_cout <= 1'b0;
              resp1_err  <= 1'b1;
            end else begin
              resp0_data <= '0;
              resp0_cout <= 1'b0;
              resp0_err  <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            if (owner) begin
              resp1_data <= alu_out;
              resp1_cout <= alu_cout;
              resp1_err  <= 1'b0;
            end else begin
              resp0_data <= alu_out;
              resp0_cout <= alu_cout;
              resp0_err  <= 1'b0;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench: requesters issue ops, a cycle-level reference model predicts grants,
// response timing and results, and a negedge monitor compares the DUT against it.
module tb_alu_rr_arbiter;
  import alu_pkg::*;

  localparam int N       = 32;
  localparam int ALU_LAT = 1;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req0_cin, req1_valid, req1_ready, req1_cin;
  logic [2:0]   req0_op, req1_op, alu_op;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic resp0_valid, resp0_ready, resp0_cout, resp0_err;
  logic resp1_valid, resp1_ready, resp1_cout, resp1_err;
  logic [N-1:0] resp0_data, resp1_data, alu_a, alu_b, alu_out;
  logic alu_cin, alu_cout, busy;

  int tests = 0;
  int fails = 0;
  logic rand_resp = 1'b0;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.N(N), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .resp0_cout(resp0_cout), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
    .resp1_cout(resp1_cout), .resp1_err(resp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout), .busy(busy)
  );

  // Behavioural ALU: returns {carry/borrow, result}.
  function automatic logic [N:0] alu_fn(input logic [2:0] op, input logic [N-1:0] a,
                                        input logic [N-1:0] b, input logic cin);
    case (op)
      OP_MOV:  return {1'b0, a};
      OP_NOT:  return {1'b0, ~a};
      OP_ADD:  return {1'b0, a} + {1'b0, b} + (N+1)'(cin);
      OP_SUB:  return {1'b0, a} - {1'b0, b} - (N+1)'(cin);
      OP_OR:   return {1'b0, a | b};
      OP_AND:  return {1'b0, a & b};
      OP_SLT:  return (N+1)'($signed(a) < $signed(b));
      default: return '0;
    endcase
  endfunction

  always_comb {alu_cout, alu_out} = alu_fn(alu_op, alu_a, alu_b, alu_cin);

  // Round-robin rule: a lone requester wins; on a tie the one not served last wins.
  function automatic logic [1:0] exp_grant(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return last ? 2'b01 : 2'b10;
    if (v0) return 2'b01;
    if (v1) return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic         owner;
    logic [N-1:0] data;
    logic         cout;
    logic         err;
  } exp_t;

  exp_t sb[$];

  // Reference model state.
  logic         m_busy = 1'b0;
  logic         m_owner = 1'b0;
  logic         m_last = 1'b1;
  int           m_delay = 0;
  logic [2:0]   m_op = '0;
  logic [N-1:0] m_a = '0, m_b = '0;
  logic         m_cin = 1'b0;

  // Monitor: compare against the model, then advance the model to the next edge.
  always @(negedge clk) begin
    logic [1:0]   eg;
    logic         id;
    logic [2:0]   op;
    logic [N-1:0] a, b;
    logic         cin;
    exp_t         e;
    if (rst) begin
      m_busy = 1'b0; m_last = 1'b1; m_delay = 0;
      m_op = '0; m_a = '0; m_b = '0; m_cin = 1'b0;
      sb.delete();
    end else begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("alu_op", 64'(alu_op), 64'(m_op));
      chk("alu_a", 64'(alu_a), 64'(m_a));
      chk("alu_b", 64'(alu_b), 64'(m_b));
      chk("alu_cin", 64'(alu_cin), 64'(m_cin));
      if (!m_busy) begin
        eg = exp_grant(req0_valid, req1_valid, m_last);
        chk("req_ready_idle", 64'({req1_ready, req0_ready}), 64'(eg));
        chk("resp_valid_idle", 64'({resp1_valid, resp0_valid}), 64'd0);
        if (eg != 2'b00) begin
          id  = eg[1];
          op  = id ? req1_op  : req0_op;
          a   = id ? req1_a   : req0_a;
          b   = id ? req1_b   : req0_b;
          cin = id ? req1_cin : req0_cin;
          m_last = id; m_owner = id; m_busy = 1'b1;
          e.owner = id;
          if (op != OP_ILL) begin
            m_op = op; m_a = a; m_b = b; m_cin = cin;
            m_delay = ALU_LAT;
            {e.cout, e.data} = alu_fn(op, a, b, cin);
            e.err = 1'b0;
          end else begin
            m_delay = 0;
            e.data = '0; e.cout = 1'b0; e.err = 1'b1;
          end
          sb.push_back(e);
        end
      end else begin
        chk("req_ready_busy", 64'({req1_ready, req0_ready}), 64'd0);
        if (m_delay > 0) begin
          chk("resp_valid_wait", 64'({resp1_valid, resp0_valid}), 64'd0);
          m_delay--;
        end else begin
          chk("resp_valid", 64'({resp1_valid, resp0_valid}), m_owner ? 64'd2 : 64'd1);
          if (m_owner ? resp1_ready : resp0_ready) begin
            if (sb.size() == 0) begin
              chk("scoreboard_nonempty", 64'd0, 64'd1);
            end else begin
              e = sb.pop_front();
              chk("resp_owner", 64'(m_owner), 64'(e.owner));
              chk("resp_data", 64'(m_owner ? resp1_data : resp0_data), 64'(e.data));
              chk("resp_cout", 64'(m_owner ? resp1_cout : resp0_cout), 64'(e.cout));
              chk("resp_err", 64'(m_owner ? resp1_err : resp0_err), 64'(e.err));
            end
            m_busy = 1'b0;
          end
        end
      end
    end
  end

  // Random response back-pressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rand_resp) begin
      resp0_ready = ($urandom_range(0, 3) != 0);
      resp1_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present one request and hold it until accepted (bounded); called just after a posedge.
  task automatic issue(input int id, input logic [2:0] op, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic cin);
    logic acc;
    int   n;
    if (id == 0) begin req0_op = op; req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1; end
    else         begin req1_op = op; req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1; end
    acc = 1'b0;
    n = 0;
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = ((id == 0) ? req0_ready : req1_ready) && !rst;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    if (id == 0) req0_valid = 1'b0;
    else         req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic rand_ops(input int id, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      idle($urandom_range(0, 3));
      issue(id, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    idle(3);
    rst = 1'b0;

    issue(0, OP_ADD, 32'hffffffff, 32'h0000000a, 1'b0);
    idle(4);

    do_reset();
    fork
      issue(0, OP_AND, 32'hfae34b91, 32'h2ba8b508, 1'b0);
      issue(1, OP_OR,  32'hfae34b91, 32'h2ba8b508, 1'b0);
    join
    idle(4);

    fork
      for (int k = 0; k < 3; k++) issue(0, 3'($urandom_range(0, 6)), $urandom, $urandom, 1'b1);
      for (int k = 0; k < 3; k++) issue(1, 3'($urandom_range(0, 6)), $urandom, $urandom, 1'b0);
    join
    idle(4);

    resp0_ready = 1'b0;
    fork
      begin
        issue(0, OP_SUB, 32'hfa230b01, 32'hfa230b01, 1'b0);
        idle(6);
        resp0_ready = 1'b1;
      end
      issue(1, OP_MOV, 32'h12345678, 32'h0, 1'b0);
    join
    idle(4);

    issue(1, OP_ILL, $urandom, $urandom, 1'b1);
    idle(4);

    issue(0, OP_MOV, 32'hfae34b91, 32'h0, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    issue(1, OP_NOT, 32'h0f0f0f0f, 32'h0, 1'b0);
    idle(4);

    rand_resp = 1'b1;
    fork
      rand_ops(0, 25);
      rand_ops(1, 25);
    join
    rand_resp = 1'b0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    for (int i = 0; i < 50 && (m_busy || sb.size() != 0); i++) idle(1);
    chk("drain_busy", 64'(m_busy), 64'd0);
    chk("drain_scoreboard", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
